barcodescanner_nios_nios2_oci_dct_packer: RTL

Upstream feeder of the OCI trace test bench. It packs 2-bit direct-compressed-trace (DCT) codes from the CPU trace path into a 30-bit buffer of up to 15 entries. It exposes the live buffer and its entry count as `dct_buffer` and `dct_count`. Completed buffers are handed to the trace FIFO through a one-entry valid/ready frame slot, and the block drives the `test_ending` / `test_has_ended` end-of-run handshake.

---
 rtl/barcodescanner_nios_oci_pkg.sv | 14 +
 rtl/barcodescanner_nios_nios2_oci_dct_slot.sv | 33 +++
 rtl/barcodescanner_nios_nios2_oci_dct_packer.sv | 102 ++++++++++
 3 files changed

// File: rtl/barcodescanner_nios_oci_pkg.sv
// Shared constants and types for the OCI direct-compressed-trace path.
package barcodescanner_nios_oci_pkg;
  localparam int DCT_SLOTS  = 15;
  localparam int DCT_CODE_W = 2;
  localparam int DCT_BUF_W  = DCT_SLOTS * DCT_CODE_W;
  localparam int DCT_CNT_W  = 4;

  localparam logic [DCT_CODE_W-1:0] DCT_NOT_TAKEN = 2'b00;
  localparam logic [DCT_CODE_W-1:0] DCT_TAKEN     = 2'b01;
  localparam logic [DCT_CODE_W-1:0] DCT_EXCEPTION = 2'b10;
  localparam logic [DCT_CODE_W-1:0] DCT_SYNC      = 2'b11;

  typedef enum logic [1:0] {RUN, ENDING, ENDED} dct_state_t;
endpackage

// File: rtl/barcodescanner_nios_nios2_oci_dct_slot.sv
// One-entry valid/ready frame register between the packer and the trace FIFO.
module barcodescanner_nios_nios2_oci_dct_slot #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_count,
  input  logic              frame_ready,
  output logic              frame_valid,
  output logic [DATA_W-1:0] frame_data,
  output logic [CNT_W-1:0]  frame_count,
  output logic              slot_free
);
  assign slot_free = !frame_valid || frame_ready;

  // A load wins over the accept so a new frame can replace the one leaving.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_count <= '0;
    end else if (load) begin
      frame_valid <= 1'b1;
      frame_data  <= load_data;
      frame_count <= load_count;
    end else if (frame_ready) begin
      frame_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/barcodescanner_nios_nios2_oci_dct_packer.sv
// Packs 2-bit DCT codes into a 15-entry buffer and hands full/flushed buffers
// to a one-entry frame slot; also runs the end-of-test drain handshake.
module barcodescanner_nios_nios2_oci_dct_packer
  import barcodescanner_nios_oci_pkg::*;
#(
  parameter int SLOTS  = DCT_SLOTS,
  parameter int CODE_W = DCT_CODE_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    code_valid,
  input  logic [CODE_W-1:0]       code,
  input  logic                    flush,
  input  logic                    end_req,
  output logic [SLOTS*CODE_W-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0]    dct_count,
  output logic                    frame_valid,
  output logic [SLOTS*CODE_W-1:0] frame_data,
  output logic [DCT_CNT_W-1:0]    frame_count,
  input  logic                    frame_ready,
  output logic                    overflow,
  output logic                    test_ending,
  output logic                    test_has_ended
);
  localparam int BUF_W = SLOTS * CODE_W;
  localparam logic [DCT_CNT_W-1:0] FULL_CNT = DCT_CNT_W'(SLOTS);

  dct_state_t             state, state_nxt;
  logic [BUF_W-1:0]       buf_nxt;
  logic [DCT_CNT_W-1:0]   cnt_nxt;
  logic                   flush_pend, flush_pend_nxt, ovf_nxt;
  logic                   slot_free, xfer, full, code_in;

  barcodescanner_nios_nios2_oci_dct_slot #(.DATA_W(BUF_W), .CNT_W(DCT_CNT_W)) u_slot (
    .clk         (clk),
    .reset       (reset),
    .load        (xfer),
    .load_data   (dct_buffer),
    .load_count  (dct_count),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_count (frame_count),
    .slot_free   (slot_free)
  );

  always_comb begin
    buf_nxt        = dct_buffer;
    cnt_nxt        = dct_count;
    flush_pend_nxt = flush_pend;
    ovf_nxt        = overflow;
    state_nxt      = state;
    full    = (dct_count == FULL_CNT);
    code_in = (state == RUN) && code_valid;
    xfer    = slot_free && (full || ((dct_count != '0) && (flush_pend || state == ENDING)));

    if (xfer) begin
      buf_nxt        = '0;
      cnt_nxt        = '0;
      flush_pend_nxt = 1'b0;
    end

    // A code on the transfer cycle lands in entry 0 of the freshly cleared buffer.
    if (code_in) begin
      if (xfer || !full) begin
        buf_nxt[int'(cnt_nxt)*CODE_W +: CODE_W] = code;
        cnt_nxt = cnt_nxt + DCT_CNT_W'(1);
      end else begin
        ovf_nxt = 1'b1;
      end
    end

    // Flush only sticks if something is left to send after this edge.
    if (state == RUN && flush && cnt_nxt != '0)
      flush_pend_nxt = 1'b1;

    case (state)
      RUN:     if (end_req) state_nxt = ENDING;
      ENDING:  if (dct_count == '0 && !frame_valid) state_nxt = ENDED;
      default: state_nxt = ENDED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_pend <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      dct_buffer <= buf_nxt;
      dct_count  <= cnt_nxt;
      flush_pend <= flush_pend_nxt;
      overflow   <= ovf_nxt;
    end
  end

  assign test_ending    = (state != RUN);
  assign test_has_ended = (state == ENDED);
endmodule
